// File: rtl/patternbuf_pkg.sv
// Shared types and defaults for the scan pattern buffer controller:
// buffer geometry, sequencer state encoding and the field-pointer decoder.
package patternbuf_pkg;

  localparam int BUF_WIDTH_DEF = 8;
  localparam int BUF_SIZE_DEF  = 32;
  localparam int ADDR_W_DEF    = $clog2(BUF_SIZE_DEF);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_SHIFT,
    CPU_RD
  } pb_state_e;

  function automatic logic [BUF_SIZE_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] addr);
    return BUF_SIZE_DEF'(1) << addr;
  endfunction

endpackage

// File: rtl/patternbuf_if.sv
// Host-loader and CPU access port of the pattern buffer controller.
// master = host/CPU side, slave = controller side.
interface patternbuf_if
  import patternbuf_pkg::*;
#(
  parameter int BUF_WIDTH = BUF_WIDTH_DEF,
  parameter int BUF_SIZE  = BUF_SIZE_DEF
);
  localparam int ADDR_W = $clog2(BUF_SIZE);

  logic                 load_start;
  logic [BUF_WIDTH-1:0] load_data;
  logic                 load_valid;
  logic                 load_ready;
  logic                 load_busy;
  logic                 load_done;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [BUF_WIDTH-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic [BUF_WIDTH-1:0] cpu_rdata;
  logic                 cpu_rvalid;

  modport master (
    output load_start, load_data, load_valid, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  load_ready, load_busy, load_done, cpu_gnt, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  load_start, load_data, load_valid, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output load_ready, load_busy, load_done, cpu_gnt, cpu_rdata, cpu_rvalid
  );

endinterface

// File: rtl/patternbuf_shifter.sv
// Byte-to-serial shifter feeding the buffer scan chain, MSB first.
// With PATBUF_UNLOAD_EN defined it also reassembles sout into unload bytes.
module patternbuf_shifter
  import patternbuf_pkg::*;
#(
  parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [BUF_WIDTH-1:0] data_i,
  output logic                 ssel_o,
  output logic                 sin_o,
  output logic                 last_o
`ifdef PATBUF_UNLOAD_EN
  ,
  input  logic                 sout_i,
  output logic [BUF_WIDTH-1:0] unload_data_o,
  output logic                 unload_valid_o
`endif
);

  localparam int CNT_W = $clog2(BUF_WIDTH);

  logic [BUF_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 active_q;
  logic                 sin_q;

  assign last_o = active_q && (bit_cnt_q == CNT_W'(BUF_WIDTH - 1));
  assign ssel_o = active_q;
  assign sin_o  = sin_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      active_q  <= 1'b0;
      sin_q     <= 1'b0;
    end else if (start_i) begin
      active_q  <= 1'b1;
      sin_q     <= data_i[BUF_WIDTH-1];
      shreg_q   <= {data_i[BUF_WIDTH-2:0], 1'b0};
      bit_cnt_q <= '0;
    end else if (active_q) begin
      if (last_o) begin
        active_q <= 1'b0;
        sin_q    <= 1'b0;
      end else begin
        sin_q     <= shreg_q[BUF_WIDTH-1];
        shreg_q   <= {shreg_q[BUF_WIDTH-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef PATBUF_UNLOAD_EN
  logic [BUF_WIDTH-2:0] des_q;
  logic [BUF_WIDTH-1:0] unload_data_q;
  logic                 unload_valid_q;

  // sout shows the outgoing bit before the chain moves on this shift cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      des_q          <= '0;
      unload_data_q  <= '0;
      unload_valid_q <= 1'b0;
    end else begin
      unload_valid_q <= 1'b0;
      if (active_q) begin
        des_q <= {des_q[BUF_WIDTH-3:0], sout_i};
        if (last_o) begin
          unload_data_q  <= {des_q, sout_i};
          unload_valid_q <= 1'b1;
        end
      end
    end
  end

  assign unload_data_o  = unload_data_q;
  assign unload_valid_o = unload_valid_q;
`endif

endmodule

// File: rtl/patternbuf_ctrl.sv
// Sequencer/arbiter sharing the scan pattern buffer between CPU field access and
// a host serial loader. PATBUF_UNLOAD_EN adds the unload_data/unload_valid outputs.
module patternbuf_ctrl
  import patternbuf_pkg::*;
#(
  parameter int BUF_WIDTH = BUF_WIDTH_DEF,
  parameter int BUF_SIZE  = BUF_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  patternbuf_if.slave          bus,
  output logic [BUF_SIZE-1:0]  fieldp,
  output logic                 field_write,
  output logic [BUF_WIDTH-1:0] field_in,
  input  logic [BUF_WIDTH-1:0] field_byte,
  output logic                 ssel,
  output logic                 sin,
  input  logic                 sout
`ifdef PATBUF_UNLOAD_EN
  ,
  output logic [BUF_WIDTH-1:0] unload_data,
  output logic                 unload_valid
`endif
);

  localparam int ADDR_W = $clog2(BUF_SIZE);
  localparam logic [ADDR_W-1:0] LAST_FIELD = ADDR_W'(BUF_SIZE - 1);

  pb_state_e            state_q;
  logic [ADDR_W-1:0]    byte_cnt_q;
  logic [BUF_SIZE-1:0]  fieldp_q;
  logic                 field_write_q;
  logic [BUF_WIDTH-1:0] field_in_q;
  logic [BUF_WIDTH-1:0] rdata_q;
  logic                 rvalid_q;
  logic                 load_ready_q;
  logic                 load_busy_q;
  logic                 load_done_q;
  logic                 shift_start;
  logic                 shift_last;

  // A load request takes priority over a CPU request arriving in the same cycle.
  assign bus.cpu_gnt = bus.cpu_req & (state_q == IDLE) & ~bus.load_start;
  assign shift_start = load_ready_q & bus.load_valid;

  patternbuf_shifter #(.BUF_WIDTH(BUF_WIDTH)) u_shifter (
    .clk            (clk),
    .reset          (reset),
    .start_i        (shift_start),
    .data_i         (bus.load_data),
    .ssel_o         (ssel),
    .sin_o          (sin),
    .last_o         (shift_last)
`ifdef PATBUF_UNLOAD_EN
    ,
    .sout_i         (sout),
    .unload_data_o  (unload_data),
    .unload_valid_o (unload_valid)
`endif
  );

`ifndef PATBUF_UNLOAD_EN
  logic unused_sout;
  assign unused_sout = sout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      fieldp_q      <= '0;
      field_write_q <= 1'b0;
      field_in_q    <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      load_ready_q  <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      fieldp_q      <= '0;
      field_write_q <= 1'b0;
      rvalid_q      <= 1'b0;
      load_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            state_q      <= LOAD_WAIT;
            byte_cnt_q   <= '0;
            load_ready_q <= 1'b1;
            load_busy_q  <= 1'b1;
          end else if (bus.cpu_gnt) begin
            fieldp_q <= BUF_SIZE'(onehot(ADDR_W_DEF'(bus.cpu_addr)));
            if (bus.cpu_we) begin
              field_write_q <= 1'b1;
              field_in_q    <= bus.cpu_wdata;
            end else begin
              state_q <= CPU_RD;
            end
          end
        end
        LOAD_WAIT: begin
          if (shift_start) begin
            state_q      <= LOAD_SHIFT;
            load_ready_q <= 1'b0;
          end
        end
        LOAD_SHIFT: begin
          if (shift_last) begin
            if (byte_cnt_q == LAST_FIELD) begin
              state_q     <= IDLE;
              load_busy_q <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= LOAD_WAIT;
              byte_cnt_q   <= byte_cnt_q + ADDR_W'(1);
              load_ready_q <= 1'b1;
            end
          end
        end
        CPU_RD: begin
          rdata_q  <= field_byte;
          rvalid_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fieldp         = fieldp_q;
  assign field_write    = field_write_q;
  assign field_in       = field_in_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_busy  = load_busy_q;
  assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_patternbuf_ctrl.sv
// Self-checking bench for patternbuf_ctrl: random CPU traffic and host loads checked
// against a field-level reference model; includes a behavioural 32x8 scan buffer.
module tb_patternbuf_ctrl;
  import patternbuf_pkg::*;

  localparam int W  = BUF_WIDTH_DEF;
  localparam int N  = BUF_SIZE_DEF;
  localparam int AW = $clog2(N);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  patternbuf_if bus_if ();

  logic [N-1:0] fieldp;
  logic         field_write;
  logic [W-1:0] field_in;
  logic [W-1:0] field_byte;
  logic         ssel;
  logic         sin;
  logic         sout;
`ifdef PATBUF_UNLOAD_EN
  logic [W-1:0] unload_data;
  logic         unload_valid;
`endif

  patternbuf_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .fieldp       (fieldp),
    .field_write  (field_write),
    .field_in     (field_in),
    .field_byte   (field_byte),
    .ssel         (ssel),
    .sin          (sin),
    .sout         (sout)
`ifdef PATBUF_UNLOAD_EN
    ,
    .unload_data  (unload_data),
    .unload_valid (unload_valid)
`endif
  );

  // Behavioural scan buffer: field k occupies chain[k*W +: W], sin enters at bit 0.
  logic [N*W-1:0] chain;
  always @(posedge clk) begin
    if (ssel) chain <= {chain[N*W-2:0], sin};
    for (int k = 0; k < N; k++)
      if (field_write && fieldp[k]) chain[k*W +: W] <= field_in;
  end
  assign sout = chain[N*W-1];
  always_comb begin
    field_byte = '0;
    for (int k = 0; k < N; k++)
      if (fieldp[k]) field_byte = chain[k*W +: W];
  end

  int ssel_cnt     = 0;
  int done_cnt     = 0;
  int overlap_cnt  = 0;
  int busy_gnt_cnt = 0;
  always @(posedge clk) begin
    if (ssel) ssel_cnt++;
    if (bus_if.load_done) done_cnt++;
    if (ssel && field_write) overlap_cnt++;
    if (bus_if.cpu_gnt && bus_if.load_busy) busy_gnt_cnt++;
  end

`ifdef PATBUF_UNLOAD_EN
  logic [W-1:0] unload_q[$];
  always @(posedge clk) if (unload_valid) unload_q.push_back(unload_data);
`endif

  // Reference model: expected field contents and whether they are defined.
  logic [W-1:0] exp_mem   [N];
  bit           exp_known [N];
  logic [W-1:0] load_bytes[N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.load_start = 1'b0;
    bus_if.load_data  = '0;
    bus_if.load_valid = 1'b0;
    bus_if.cpu_req    = 1'b0;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_addr   = '0;
    bus_if.cpu_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fieldp", 32'(fieldp), 0);
    check("rst_ssel", 32'(ssel), 0);
    check("rst_field_write", 32'(field_write), 0);
    check("rst_load_ready", 32'(bus_if.load_ready), 0);
    check("rst_load_busy", 32'(bus_if.load_busy), 0);
    check("rst_load_done", 32'(bus_if.load_done), 0);
    check("rst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus_if.load_ready), 0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = 1'b1;
    bus_if.cpu_addr  = a;
    bus_if.cpu_wdata = d;
    #1;
    check("wr_gnt", 32'(bus_if.cpu_gnt), 1);
    tick();
    check("wr_fieldp", 32'(fieldp), 32'd1 << a);
    check("wr_field_in", 32'(field_in), 32'(d));
    check("wr_strobe", 32'(field_write), 1);
    bus_if.cpu_req = 1'b0;
    exp_mem[a]   = d;
    exp_known[a] = 1'b1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = a;
    #1;
    check("rd_gnt", 32'(bus_if.cpu_gnt), 1);
    tick();
    check("rd_fieldp", 32'(fieldp), 32'd1 << a);
    check("rd_no_second_gnt", 32'(bus_if.cpu_gnt), 0);
    check("rd_rvalid_early", 32'(bus_if.cpu_rvalid), 0);
    bus_if.cpu_req = 1'b0;
    tick();
    check("rd_rvalid", 32'(bus_if.cpu_rvalid), 1);
    check("rd_fieldp_clear", 32'(fieldp), 0);
    if (exp_known[a]) check("rd_data", 32'(bus_if.cpu_rdata), 32'(exp_mem[a]));
  endtask

  task automatic random_ops(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) cpu_write(a, W'($urandom));
      else cpu_read(a);
    end
    bus_if.cpu_req = 1'b0;
    tick();
  endtask

  task automatic host_load(input bit with_cpu, input int abort_at);
    int s0, d0, b0, u0;
    bit all_known, stall_ssel;
    logic [W-1:0] exp_unload[N];
    s0 = ssel_cnt; d0 = done_cnt; b0 = busy_gnt_cnt; u0 = 0;
`ifdef PATBUF_UNLOAD_EN
    u0 = unload_q.size();
`endif
    all_known  = 1'b1;
    stall_ssel = 1'b0;
    for (int j = 0; j < N; j++) begin
      all_known &= exp_known[N-1-j];
      exp_unload[j] = exp_mem[N-1-j];
    end

    bus_if.load_start = 1'b1;
    if (with_cpu) begin
      bus_if.cpu_req  = 1'b1;
      bus_if.cpu_we   = 1'b0;
      bus_if.cpu_addr = '0;
    end
    #1;
    check("start_gnt_blocked", 32'(bus_if.cpu_gnt), 0);
    tick();
    bus_if.load_start = 1'b0;
    check("start_busy", 32'(bus_if.load_busy), 1);
    check("start_ready", 32'(bus_if.load_ready), 1);

    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) begin
        bus_if.load_valid = 1'b0;
        tick();
        stall_ssel |= ssel;
      end
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = load_bytes[i];
      tick();
      bus_if.load_valid = 1'b0;
      if (i == abort_at) begin
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("abort_ssel", 32'(ssel), 0);
        check("abort_busy", 32'(bus_if.load_busy), 0);
        bus_if.cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("abort_ready", 32'(bus_if.load_ready), 0);
        for (int k = 0; k < N; k++) exp_known[k] = 1'b0;
        return;
      end
      for (int c = 0; c < 2 * W && !(bus_if.load_ready || bus_if.load_done); c++) tick();
      if (i == N - 1) check("last_byte_done", 32'(bus_if.load_done), 1);
      else check("byte_ready", 32'(bus_if.load_ready), 1);
    end

    check("done_busy", 32'(bus_if.load_busy), 0);
    check("done_ready", 32'(bus_if.load_ready), 0);
    for (int k = 0; k < N; k++) begin
      exp_mem[k]   = load_bytes[N-1-k];
      exp_known[k] = 1'b1;
    end
    if (with_cpu) begin
      check("gnt_at_done", 32'(bus_if.cpu_gnt), 1);
      tick();
      bus_if.cpu_req = 1'b0;
      tick();
      check("post_load_rvalid", 32'(bus_if.cpu_rvalid), 1);
      check("post_load_rdata", 32'(bus_if.cpu_rdata), 32'(exp_mem[0]));
    end
    tick();
    check("stall_ssel", 32'(stall_ssel), 0);
    check("ssel_total", 32'(ssel_cnt - s0), N * W);
    check("done_count", 32'(done_cnt - d0), 1);
    check("gnt_while_busy", 32'(busy_gnt_cnt - b0), 0);
`ifdef PATBUF_UNLOAD_EN
    if (all_known) begin
      check("unload_count", 32'(unload_q.size() - u0), N);
      for (int j = 0; j < N && u0 + j < unload_q.size(); j++)
        check("unload_byte", 32'(unload_q[u0+j]), 32'(exp_unload[j]));
    end
`else
    if (all_known && u0 != 0) check("unload_unexpected", 32'(u0), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    do_reset();

    cpu_write(AW'(5), 8'hA5);
    tick();
    check("wr_strobe_once", 32'(field_write), 0);
    check("wr_fieldp_clear", 32'(fieldp), 0);

    cpu_write(AW'(31), 8'h3C);
    cpu_read(AW'(31));

    random_ops(24);

    for (int k = 0; k < N; k++) load_bytes[k] = W'(k);
    host_load(1'b1, -1);
    for (int k = 0; k < N; k++) begin
      cpu_read(AW'(k));
      check("field_k_is_31_minus_k", 32'(bus_if.cpu_rdata), 32'(N - 1 - k));
    end

    for (int k = 0; k < N; k++) load_bytes[k] = W'($urandom);
    host_load(1'b0, -1);
    random_ops(16);

    for (int k = 0; k < N; k++) load_bytes[k] = W'($urandom);
    host_load(1'b0, 10);

    for (int k = 0; k < N; k++) load_bytes[k] = W'($urandom);
    host_load(1'b0, -1);
    for (int k = 0; k < N; k++) cpu_read(AW'(k));

    random_ops(32);
    check("ssel_write_overlap", 32'(overlap_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
